param_pio_bank: RTL
===================

PARAM_PIO_BANK -- requirements
Module: param_pio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 6, bits per channel (legal 1..32).
REQ-002 SHALL have parameter NUM_CH, default 4, channel count (legal 1..8).
REQ-003 SHALL have parameter RESET_VAL, default 0, reset value of every shadow and active register (truncated to WIDTH).
REQ-004 SHALL have ports: clk  input  1  clock; reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: address  input  5  Avalon-MM word address.
REQ-006 SHALL have ports: chipselect  input  1; write_n  input  1  active-low write; writedata  input  32.
REQ-007 SHALL have port: readdata  output  32  combinational, zero wait states.
REQ-008 SHALL have port: sync_commit  input  1  single-cycle pulse from the processing pipeline (e.g. frame boundary).
REQ-009 SHALL have port: out_port  output  NUM_CH*WIDTH  active registers; channel k is at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port: commit_pulse  output  1  high for exactly one cycle after each commit.

Function
REQ-011 SHALL map address 0..NUM_CH-1 to the SHADOW[k] registers; a write loads writedata[WIDTH-1:0]; a read returns SHADOW[k] zero-extended.
REQ-012 SHALL map address 8 to CTRL: bit0 COMMIT (write-1 pulse, reads 0), bit1 ARM (sticky), bit2 AUTO (sticky).
REQ-013 SHALL map address 9 to STATUS (read-only): bit0 PENDING, bit1 ARMED state, bits[15:8] COMMIT_CNT.
REQ-014 SHALL return 0 on reads of unmapped addresses or channels >= NUM_CH; writes to them SHALL be ignored.
REQ-015 SHALL set PENDING on any shadow write and clear it on commit; PENDING SHALL stay set when a shadow write and a commit occur on the same edge.
REQ-016 SHALL implement FSM IDLE -> ARMED on a CTRL write with ARM=1 while PENDING; ARMED -> COMMIT on sync_commit; IDLE -> COMMIT on a CTRL write with COMMIT=1; COMMIT -> IDLE unconditionally after one cycle.
REQ-017 SHALL leave the FSM in IDLE when sync_commit arrives in IDLE; ARMED SHALL return to IDLE on a CTRL write with ARM=0.
REQ-018 SHALL, in COMMIT, copy every SHADOW[k] to ACTIVE[k] simultaneously, so out_port changes one clock after entering COMMIT.
REQ-019 SHALL assert commit_pulse in the same cycle that out_port updates.
REQ-020 SHALL take the shadow value present before the edge when a shadow write coincides with the COMMIT-state copy; the new value remains pending.
REQ-021 SHALL, with AUTO=1, commit each shadow write through the FSM (COMMIT on the next cycle), giving out_port latency 2 cycles from the write; ARM SHALL be ignored while AUTO=1.
REQ-022 SHALL increment COMMIT_CNT (8 bits) on every commit, wrapping 255 -> 0.
REQ-023 SHALL give a software COMMIT priority over a pending ARMED state; the resulting single commit SHALL count once.

Reset
REQ-024 SHALL, on reset_n low, asynchronously set all SHADOW and ACTIVE registers to RESET_VAL, CTRL bits to 0, PENDING to 0, COMMIT_CNT to 0, FSM to IDLE, and commit_pulse to 0.
REQ-025 SHALL abort a mid-commit reset with no partial update: out_port equals RESET_VAL for every channel.

Configuration
REQ-026 SHALL provide macro PARAM_PIO_READBACK_EN; when defined, addresses 16..16+NUM_CH-1 SHALL read ACTIVE[k] zero-extended.
REQ-027 SHALL, when PARAM_PIO_READBACK_EN is undefined, return 0 on those addresses and synthesise no readback mux.

Structure
REQ-028 SHALL place the address constants (SHADOW_BASE=0, CTRL=8, STATUS=9, ACTIVE_BASE=16), the CTRL bit indices, and the FSM state typedef in the shared package param_pio_pkg.
REQ-029 SHALL contain one sub-module, param_pio_commit_fsm, holding the FSM, the PENDING flag and COMMIT_CNT; the register file and read mux SHALL stay in the top level.

Verification
REQ-030 SHALL cover: reset, then read channels 0..3 -> all read 0, out_port=0, STATUS=0.
REQ-031 SHALL cover: write 0x2A to ch1, then CTRL=0x1 -> out_port[11:6]=0x2A one cycle after COMMIT, commit_pulse high 1 cycle, COMMIT_CNT=1, PENDING=0.
REQ-032 SHALL cover: write 0x15 to ch0, CTRL=0x2, wait 10 cycles, pulse sync_commit -> out_port unchanged until the pulse, updated 2 cycles after it.
REQ-033 SHALL cover: shadow write 0x3F to ch2 on the same edge as the COMMIT-state copy -> old value committed, PENDING=1 afterwards.
REQ-034 SHALL cover: 256 commits -> COMMIT_CNT wraps to 0; with AUTO=1, writing 0x07 to ch3 -> out_port[23:18]=0x07 two cycles later.
REQ-035 SHALL cover: reset_n low during COMMIT -> all out_port channels equal RESET_VAL, FSM in IDLE.

Source files
------------

// File: rtl/param_pio_bank_pkg.sv
// Shared constants and types for the parameterised PIO bank: register map,
// CTRL/STATUS bit positions and the commit FSM state encoding.
package param_pio_pkg;

    localparam logic [4:0] ADDR_SHADOW_BASE = 5'd0;
    localparam logic [4:0] ADDR_CTRL        = 5'd8;
    localparam logic [4:0] ADDR_STATUS      = 5'd9;
    localparam logic [4:0] ADDR_ACTIVE_BASE = 5'd16;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ARM_BIT    = 1;
    localparam int CTRL_AUTO_BIT   = 2;

    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_ARMED_BIT   = 1;
    localparam int STAT_CNT_LSB     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } pio_state_e;

endpackage

// File: rtl/param_pio_bank_if.sv
// Avalon-MM slave bus of the PIO bank (word address, zero-wait-state reads).
interface param_pio_bank_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/param_pio_bank_commit_fsm.sv
// Commit sequencer: decides when the shadow bank is copied to the active bank,
// and tracks the PENDING flag and the wrapping commit counter.
module param_pio_commit_fsm
    import param_pio_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       shadow_wr_i,
    input  logic       ctrl_wr_i,
    input  logic       ctrl_commit_i,
    input  logic       ctrl_arm_i,
    input  logic       ctrl_auto_i,
    input  logic       auto_i,
    input  logic       sync_commit_i,
    output logic       copy_o,
    output logic       commit_pulse_o,
    output logic       pending_o,
    output logic       armed_o,
    output logic [7:0] commit_cnt_o
);

    pio_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pulse_q;
    logic       go_commit;

    always_comb begin
        state_d   = state_q;
        go_commit = (ctrl_wr_i && ctrl_commit_i) || (auto_i && shadow_wr_i);
        unique case (state_q)
            ST_IDLE: begin
                if (go_commit)
                    state_d = ST_COMMIT;
                else if (ctrl_wr_i && ctrl_arm_i && !ctrl_auto_i && !auto_i && pending_q)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A software commit while armed still yields exactly one copy.
                if (go_commit || sync_commit_i)
                    state_d = ST_COMMIT;
                else if (ctrl_wr_i && !ctrl_arm_i)
                    state_d = ST_IDLE;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A write landing on the copy edge is not in the copy, so it stays pending.
        pending_d = pending_q;
        if (shadow_wr_i)
            pending_d = 1'b1;
        else if (state_q == ST_COMMIT)
            pending_d = 1'b0;

        cnt_d = cnt_q + ((state_q == ST_COMMIT) ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            cnt_q     <= 8'd0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            pulse_q   <= (state_q == ST_COMMIT);
        end
    end

    assign copy_o         = (state_q == ST_COMMIT);
    assign commit_pulse_o = pulse_q;
    assign pending_o      = pending_q;
    assign armed_o        = (state_q == ST_ARMED);
    assign commit_cnt_o   = cnt_q;

endmodule

// File: rtl/param_pio_bank.sv
// Double-buffered PIO bank: software fills SHADOW registers, a commit copies all
// of them to ACTIVE/out_port at once. Define PARAM_PIO_READBACK_EN to read ACTIVE.
module param_pio_bank
    import param_pio_pkg::*;
#(
    parameter int          WIDTH     = 6,
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    param_pio_bank_if.slave           bus,
    input  logic                      sync_commit,
    output logic [NUM_CH*WIDTH-1:0]   out_port,
    output logic                      commit_pulse
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] active_q [NUM_CH];
    logic             arm_q, auto_q;
    logic [NUM_CH-1:0] shadow_wr;
    logic             wr_en, ctrl_wr, copy;
    logic             pending, armed;
    logic [7:0]       commit_cnt;
    logic [31:0]      rdata;

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign ctrl_wr = wr_en && (bus.address == ADDR_CTRL);

    always_comb begin
        shadow_wr = '0;
        for (int k = 0; k < NUM_CH; k++)
            shadow_wr[k] = wr_en && (bus.address == ADDR_SHADOW_BASE + 5'(k));
    end

    param_pio_commit_fsm u_fsm (
        .clk            (clk),
        .reset_n        (reset_n),
        .shadow_wr_i    (|shadow_wr),
        .ctrl_wr_i      (ctrl_wr),
        .ctrl_commit_i  (bus.writedata[CTRL_COMMIT_BIT]),
        .ctrl_arm_i     (bus.writedata[CTRL_ARM_BIT]),
        .ctrl_auto_i    (bus.writedata[CTRL_AUTO_BIT]),
        .auto_i         (auto_q),
        .sync_commit_i  (sync_commit),
        .copy_o         (copy),
        .commit_pulse_o (commit_pulse),
        .pending_o      (pending),
        .armed_o        (armed),
        .commit_cnt_o   (commit_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= RST_V;
                active_q[k] <= RST_V;
            end
            arm_q  <= 1'b0;
            auto_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (shadow_wr[k])
                    shadow_q[k] <= bus.writedata[WIDTH-1:0];
                if (copy)
                    active_q[k] <= shadow_q[k];
            end
            if (ctrl_wr) begin
                arm_q  <= bus.writedata[CTRL_ARM_BIT];
                auto_q <= bus.writedata[CTRL_AUTO_BIT];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (bus.address == ADDR_SHADOW_BASE + 5'(k))
                rdata[WIDTH-1:0] = shadow_q[k];
        if (bus.address == ADDR_CTRL) begin
            rdata[CTRL_ARM_BIT]  = arm_q;
            rdata[CTRL_AUTO_BIT] = auto_q;
        end
        if (bus.address == ADDR_STATUS) begin
            rdata[STAT_PENDING_BIT]            = pending;
            rdata[STAT_ARMED_BIT]              = armed;
            rdata[STAT_CNT_LSB +: 8]           = commit_cnt;
        end
`ifdef PARAM_PIO_READBACK_EN
        for (int k = 0; k < NUM_CH; k++)
            if (bus.address == ADDR_ACTIVE_BASE + 5'(k))
                rdata[WIDTH-1:0] = active_q[k];
`endif
    end

    assign bus.readdata = rdata;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign out_port[k*WIDTH +: WIDTH] = active_q[k];
    end

endmodule
